// File: rtl/spi_bus_master.sv
// Purpose : runs one SPI-originated RAM transaction on the shared bus, only inside SPI-granted slots.
// Latency : response 13 clocks after the qualifying strobe (defaults); acceptance-to-response up to ~512 clocks.
// Backpres: req_ready is low from acceptance until the response clock; one request is held at a time.
//
// Ports:
//   clock_i, reset_n_i           clock and asynchronous active-low reset
//   spi_grant_i, strobe_i        slot ownership and slot-start pulse from the bus timing generator
//   req_*                        valid/ready request (we, addr, write data) from the SPI target logic
//   rsp_valid_o, rsp_data_o      one-clock completion pulse with read data
//   bus_*, ram_*                 shared bus address/data drivers and active-low RAM enables
module spi_bus_master #(
    parameter int ADDR_WIDTH    = 17,
    parameter int DATA_WIDTH    = 8,
    parameter int SETUP_CYCLES  = 2,
    parameter int ACCESS_CYCLES = 8,
    parameter int HOLD_CYCLES   = 2
) (
    input  logic                  clock_i,
    input  logic                  reset_n_i,
    input  logic                  spi_grant_i,
    input  logic                  strobe_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_data_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic                  bus_active_o,
    output logic [ADDR_WIDTH-1:0] bus_addr_o,
    output logic [DATA_WIDTH-1:0] bus_data_o,
    output logic                  bus_data_oe_o,
    input  logic [DATA_WIDTH-1:0] bus_data_i,
    output logic                  ram_oe_n_o,
    output logic                  ram_we_n_o
);

    // Wide enough for any phase length that still fits a 62-clock sequence.
    localparam int CNT_W = 6;

    localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACCESS_LOAD = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_SETUP  = 3'd2;
    localparam logic [2:0] S_ACCESS = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;

    logic [2:0]            state;
    logic [2:0]            state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_nxt;
    logic                  lat_we;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_data;
    logic [DATA_WIDTH-1:0] rd_cap;
    logic                  accept;
    logic                  last_access;
    logic                  last_hold;
    logic                  nxt_on_bus;
    logic                  nxt_access;

    assign accept      = (state == S_IDLE) && req_valid_i && req_ready_o;
    // Phase ends only if the grant is still held; a dropped grant overrides completion.
    assign last_access = (state == S_ACCESS) && (cnt == '0) && spi_grant_i;
    assign last_hold   = (state == S_HOLD) && (cnt == '0) && spi_grant_i;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (strobe_i && spi_grant_i) begin
                    state_nxt = S_SETUP;
                    cnt_nxt   = SETUP_LOAD;
                end
            end
            S_SETUP, S_ACCESS, S_HOLD: begin
                if (!spi_grant_i) begin
                    // Lost the slot: release the bus and retry the whole sequence later.
                    state_nxt = S_WAIT;
                    cnt_nxt   = '0;
                end else if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else if (state == S_SETUP) begin
                    state_nxt = S_ACCESS;
                    cnt_nxt   = ACCESS_LOAD;
                end else if (state == S_ACCESS) begin
                    state_nxt = S_HOLD;
                    cnt_nxt   = HOLD_LOAD;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    assign nxt_on_bus = (state_nxt == S_SETUP) || (state_nxt == S_ACCESS) || (state_nxt == S_HOLD);
    assign nxt_access = (state_nxt == S_ACCESS);

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state         <= S_IDLE;
            cnt           <= '0;
            lat_we        <= 1'b0;
            lat_addr      <= '0;
            lat_data      <= '0;
            rd_cap        <= '0;
            req_ready_o   <= 1'b1;
            rsp_valid_o   <= 1'b0;
            rsp_data_o    <= '0;
            bus_active_o  <= 1'b0;
            bus_addr_o    <= '0;
            bus_data_o    <= '0;
            bus_data_oe_o <= 1'b0;
            ram_oe_n_o    <= 1'b1;
            ram_we_n_o    <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;

            if (accept) begin
                lat_we   <= req_we_i;
                lat_addr <= req_addr_i;
                lat_data <= req_data_i;
            end

            // Read data is taken on the edge closing the final enable clock.
            if (last_access) begin
                rd_cap <= bus_data_i;
            end

            rsp_valid_o <= last_hold;
            if (last_hold && !lat_we) begin
                rsp_data_o <= rd_cap;
            end

            req_ready_o   <= (state_nxt == S_IDLE);
            bus_active_o  <= nxt_on_bus;
            bus_addr_o    <= nxt_on_bus ? lat_addr : '0;
            bus_data_o    <= (nxt_on_bus && lat_we) ? lat_data : '0;
            bus_data_oe_o <= nxt_on_bus && lat_we;
            ram_we_n_o    <= !(nxt_access && lat_we);
            ram_oe_n_o    <= !(nxt_access && !lat_we);
        end
    end

endmodule

// File: tb/tb_spi_bus_master.sv
// Purpose : randomized scoreboard bench for spi_bus_master against a slot-level reference model.
// Latency : expectations per clock; responses checked against their predicted clock and data.
// Backpres: requests are only offered when the model predicts the block is idle.
module tb_spi_bus_master;

    localparam int AW   = 17;
    localparam int DW   = 8;
    localparam int SC   = 2;
    localparam int AC   = 8;
    localparam int HC   = 2;
    localparam int L    = SC + AC + HC;
    localparam int SLOT = 64;

    logic          clock_i = 1'b0;
    logic          reset_n_i;
    logic          spi_grant_i;
    logic          strobe_i;
    logic          req_valid_i;
    logic          req_ready_o;
    logic          req_we_i;
    logic [AW-1:0] req_addr_i;
    logic [DW-1:0] req_data_i;
    logic          rsp_valid_o;
    logic [DW-1:0] rsp_data_o;
    logic          bus_active_o;
    logic [AW-1:0] bus_addr_o;
    logic [DW-1:0] bus_data_o;
    logic          bus_data_oe_o;
    logic [DW-1:0] bus_data_i;
    logic          ram_oe_n_o;
    logic          ram_we_n_o;

    spi_bus_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .SETUP_CYCLES(SC), .ACCESS_CYCLES(AC), .HOLD_CYCLES(HC)
    ) dut (
        .clock_i(clock_i), .reset_n_i(reset_n_i),
        .spi_grant_i(spi_grant_i), .strobe_i(strobe_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_we_i(req_we_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
        .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
        .bus_active_o(bus_active_o), .bus_addr_o(bus_addr_o),
        .bus_data_o(bus_data_o), .bus_data_oe_o(bus_data_oe_o),
        .bus_data_i(bus_data_i),
        .ram_oe_n_o(ram_oe_n_o), .ram_we_n_o(ram_we_n_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct {
        int            cyc;
        logic          ready;
        logic          active;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          oe;
        logic          oe_n;
        logic          we_n;
    } bus_exp_t;

    typedef struct {
        int            cyc;
        logic [DW-1:0] data;
    } rsp_exp_t;

    bus_exp_t exp_q[$];
    rsp_exp_t rsp_q[$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s cyc=%0d got=0x%0h expected=0x%0h", name, c, act, expv);
        end
    endtask

    function automatic logic [DW-1:0] mem_init(input logic [AW-1:0] a);
        if (a == 17'h1F000) return 8'hA5;
        return a[7:0] ^ a[15:8] ^ {7'b0, a[16]} ^ 8'h5A;
    endfunction

    // RAM behind the bus: writes on enabled clocks, read data presented for the next sampling edge.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    bit ram_ready = 1'b0;
    always @(posedge clock_i) begin
        if (!ram_ready) begin
            for (int i = 0; i < (1 << AW); i++) ram[i] = mem_init(AW'(i));
            ram_ready = 1'b1;
        end else if (!ram_we_n_o) begin
            ram[bus_addr_o] <= bus_data_o;
        end
    end
    always @(negedge clock_i) begin
        bus_data_i <= !ram_oe_n_o ? ram[bus_addr_o] : DW'($urandom);
    end

    // Monitor: pops per-clock bus expectations, and a response expectation whenever rsp_valid_o is seen.
    always @(negedge clock_i) begin
        bus_exp_t e;
        rsp_exp_t r;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("req_ready", e.cyc, req_ready_o, e.ready);
            chk("bus_active", e.cyc, bus_active_o, e.active);
            chk("bus_addr", e.cyc, bus_addr_o, e.addr);
            chk("bus_data", e.cyc, bus_data_o, e.data);
            chk("bus_data_oe", e.cyc, bus_data_oe_o, e.oe);
            chk("ram_oe_n", e.cyc, ram_oe_n_o, e.oe_n);
            chk("ram_we_n", e.cyc, ram_we_n_o, e.we_n);
            if (rsp_valid_o) begin
                if (rsp_q.size() == 0) begin
                    chk("rsp_unexpected", e.cyc, rsp_valid_o, 0);
                end else begin
                    r = rsp_q.pop_front();
                    chk("rsp_cycle", e.cyc, e.cyc, r.cyc);
                    chk("rsp_data", e.cyc, rsp_data_o, r.data);
                end
            end
        end
    end

    // Reference model: a pending request starts on the first later SPI strobe and then
    // owns the bus for L clocks, unless the grant disappears first.
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int            cyc     = 0;
    bit            m_busy  = 1'b0;
    int            m_start = -1;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [DW-1:0] m_last_rsp = '0;
    int            drop_at = -1;
    bit            drop_req = 1'b0;

    function automatic bit is_strobe(input int c);
        return (c % SLOT) == 0;
    endfunction

    function automatic bit is_spi(input int c);
        int s;
        s = (c / SLOT) % 8;
        return (s == 2) || (s == 6);
    endfunction

    function automatic bit grant_at(input int c);
        return is_spi(c) && !(drop_at >= 0 && c >= drop_at && (c / SLOT) == (drop_at / SLOT));
    endfunction

    task automatic step(input bit rst, input bit v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus_exp_t e;
        rsp_exp_t r;
        bit g, s;
        int k;
        if (drop_req && m_start >= 0 && drop_at < 0) begin
            drop_at  = m_start + 5;
            drop_req = 1'b0;
        end
        g = grant_at(cyc);
        s = is_strobe(cyc);
        if (rst) begin
            m_busy     = 1'b0;
            m_start    = -1;
            m_last_rsp = '0;
        end
        e.cyc = cyc; e.ready = !m_busy; e.active = 1'b0; e.addr = '0; e.data = '0;
        e.oe = 1'b0; e.oe_n = 1'b1; e.we_n = 1'b1;
        if (m_busy && m_start >= 0) begin
            k = cyc - m_start;
            e.active = 1'b1;
            e.addr   = m_addr;
            e.data   = m_we ? m_data : '0;
            e.oe     = m_we;
            e.we_n   = !((k > SC) && (k <= SC + AC) && m_we);
            e.oe_n   = !((k > SC) && (k <= SC + AC) && !m_we);
        end
        exp_q.push_back(e);

        reset_n_i   = !rst;
        strobe_i    = s;
        spi_grant_i = g;
        req_valid_i = v;
        req_we_i    = we;
        req_addr_i  = a;
        req_data_i  = d;

        if (!rst) begin
            if (!m_busy) begin
                if (v) begin
                    m_busy = 1'b1; m_start = -1; m_we = we; m_addr = a; m_data = d;
                end
            end else if (m_start < 0) begin
                if (s && g) m_start = cyc;
            end else begin
                k = cyc - m_start;
                if (!g) begin
                    m_start = -1;
                end else if (k == L) begin
                    r.cyc = cyc + 1;
                    if (m_we) begin
                        ref_mem[m_addr] = m_data;
                        r.data = m_last_rsp;
                    end else begin
                        m_last_rsp = ref_mem[m_addr];
                        r.data = m_last_rsp;
                    end
                    rsp_q.push_back(r);
                    m_busy  = 1'b0;
                    m_start = -1;
                end
            end
        end
        @(posedge clock_i);
        #1;
        cyc++;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    // align: 0 = soon after idle, 1 = on an SPI strobe clock, 2 = mid CPU slot.
    task automatic do_txn(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int align, input bit drop, input bit rst_mid);
        int guard;
        drop_at  = -1;
        drop_req = drop;
        guard    = 0;
        while (m_busy && guard < 3000) begin idle(); guard++; end
        if (align == 0) begin
            repeat ($urandom_range(0, 3)) idle();
        end else if (align == 1) begin
            while (!(is_strobe(cyc) && is_spi(cyc))) idle();
        end else begin
            while (!((cyc % SLOT) == 10 && ((cyc / SLOT) % 8) == 0)) idle();
        end
        step(1'b0, 1'b1, we, a, d);
        guard = 0;
        if (rst_mid) begin
            while (!(m_start >= 0 && cyc == m_start + SC + 3) && guard < 3000) begin idle(); guard++; end
            step(1'b1, 1'b0, 1'b0, '0, '0);
            step(1'b1, 1'b0, 1'b0, '0, '0);
            repeat (600) idle();
        end else begin
            while (m_busy && guard < 3000) begin idle(); guard++; end
        end
        chk("model_guard", cyc, (guard < 3000) ? 32'd1 : 32'd0, 32'd1);
    endtask

    logic [AW-1:0] pool [0:5];

    initial begin
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = mem_init(AW'(i));
        pool[0] = 17'h1F000; pool[1] = 17'h08000; pool[2] = 17'h00010;
        pool[3] = 17'h1FFFF; pool[4] = 17'h00000; pool[5] = 17'h0ABCD;
        reset_n_i = 1'b0; spi_grant_i = 1'b0; strobe_i = 1'b0; req_valid_i = 1'b0;
        req_we_i = 1'b0; req_addr_i = '0; req_data_i = '0;
        @(posedge clock_i);
        #1;
        repeat (3) step(1'b1, 1'b0, 1'b0, '0, '0);

        do_txn(1'b0, 17'h1F000, 8'h00, 2, 1'b0, 1'b0);   // read in CPU slot, waits past video strobe
        do_txn(1'b1, 17'h08000, 8'h3C, 0, 1'b0, 1'b0);   // write
        do_txn(1'b0, 17'h08000, 8'h00, 0, 1'b0, 1'b0);   // read back written byte
        do_txn(1'b0, 17'h0ABCD, 8'h00, 1, 1'b0, 1'b0);   // accepted on SPI strobe clock
        do_txn(1'b1, 17'h00010, 8'h77, 0, 1'b1, 1'b0);   // grant drop mid-write, retried
        do_txn(1'b0, 17'h00010, 8'h00, 0, 1'b1, 1'b0);   // grant drop mid-read, retried
        do_txn(1'b0, 17'h00010, 8'h00, 0, 1'b0, 1'b0);
        do_txn(1'b0, 17'h1F000, 8'h00, 0, 1'b0, 1'b1);   // reset during ACCESS
        do_txn(1'b1, 17'h1FFFF, 8'hC3, 0, 1'b0, 1'b0);   // write response shows cleared rsp_data

        for (int n = 0; n < 30; n++) begin
            logic [AW-1:0] a;
            a = ($urandom_range(0, 3) == 0) ? AW'($urandom) : pool[$urandom_range(0, 5)];
            do_txn(1'($urandom), a, DW'($urandom), int'($urandom_range(0, 2)),
                   ($urandom_range(0, 5) == 0), 1'b0);
        end

        repeat (5) idle();
        chk("rsp_missing", cyc, rsp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_bus_master.md
# spi_bus_master

Executes single SPI-originated memory transactions on the shared PET bus, but only inside the SPI time slots issued by the bus timing generator. It accepts one request at a time from the SPI target logic over a valid/ready handshake and holds it until the next slot-start strobe that coincides with an SPI grant. It then drives a fixed setup/access/hold sequence on the RAM address, data and control lines and returns a single-cycle response carrying the read data.

## Interface
- ADDR_WIDTH, 17, width of bus address
- DATA_WIDTH, 8, width of bus data
- SETUP_CYCLES, 2, clocks of address/data setup before strobe (≥1)
- ACCESS_CYCLES, 8, clocks RAM enable is asserted (≥1)
- HOLD_CYCLES, 2, clocks address/data held after enable drops (≥1)
- Constraint: SETUP_CYCLES + ACCESS_CYCLES + HOLD_CYCLES ≤ 62, so the sequence fits one 64-clock slot.

- clock_i  in  1  system clock; all state advances on the rising edge
- reset_n_i  in  1  reset, asynchronous, active-low
- spi_grant_i  in  1  high while the current slot belongs to SPI
- strobe_i  in  1  one-clock pulse in the first clock of a slot
- req_valid_i  in  1  SPI logic presents a request
- req_ready_o  out  1  block can accept a request
- req_we_i  in  1  1 = write, 0 = read
- req_addr_i  in  ADDR_WIDTH  request address
- req_data_i  in  DATA_WIDTH  write data
- rsp_valid_o  out  1  one-clock completion pulse
- rsp_data_o  out  DATA_WIDTH  read data; valid when rsp_valid_o is high
- bus_active_o  out  1  block owns the bus (SETUP/ACCESS/HOLD)
- bus_addr_o  out  ADDR_WIDTH  address driven to the bus
- bus_data_o  out  DATA_WIDTH  write data driven to the bus
- bus_data_oe_o  out  1  enable for the bus data driver
- bus_data_i  in  DATA_WIDTH  data read from the bus
- ram_oe_n_o  out  1  RAM output enable, active-low
- ram_we_n_o  out  1  RAM write enable, active-low

## Operation
- States: IDLE, WAIT, SETUP, ACCESS, HOLD.
- IDLE: req_ready_o=1. On req_valid_i && req_ready_o, latch we/addr/data and go to WAIT.
- WAIT: req_ready_o=0. On strobe_i && spi_grant_i, go to SETUP. strobe_i without spi_grant_i is ignored.
- A request accepted on a strobe cycle is not started by that strobe. It waits for the next qualifying strobe.
- SETUP: bus_active_o=1. bus_addr_o is the latched address. For writes, bus_data_o is the latched data and bus_data_oe_o=1.
- ACCESS: same as SETUP, plus ram_we_n_o=0 for writes or ram_oe_n_o=0 for reads.
- HOLD: enables return high. Address, data and oe remain as in SETUP.
- After HOLD: go to IDLE and pulse rsp_valid_o for one clock.
- For reads, rsp_data_o is bus_data_i as sampled on the edge that ends the last ACCESS cycle. For writes, rsp_data_o keeps its previous value.
- Outside SETUP/ACCESS/HOLD: bus_active_o=0, bus_data_oe_o=0, ram_oe_n_o=1, ram_we_n_o=1, bus_addr_o=0, bus_data_o=0.
- Phase counter: ceil(log2(62)) bits. It is loaded per phase and counts down to 0; no wrap-around is possible.
- spi_grant_i falling during SETUP/ACCESS/HOLD: the next clock releases the bus (all bus outputs inactive), returns to WAIT with the request retained, and produces no response. The transaction retries in full at the next qualifying strobe.
- Reset assertion at any time, including mid-transaction: all outputs take their reset values immediately and any latched request is discarded.

## Timing
- Reset values: req_ready_o=1, rsp_valid_o=0, rsp_data_o=0, bus_active_o=0, bus_addr_o=0, bus_data_o=0, bus_data_oe_o=0, ram_oe_n_o=1, ram_we_n_o=1.
- All outputs are registered.
- Qualifying strobe in clock T:
  - SETUP: T+1 … T+SETUP_CYCLES
  - ACCESS: the next ACCESS_CYCLES clocks
  - HOLD: the next HOLD_CYCLES clocks
  - rsp_valid_o high in the following clock, with req_ready_o=1 in that same clock.
- Defaults: SETUP T+1–T+2, ACCESS T+3–T+10, HOLD T+11–T+12, rsp_valid_o at T+13.
- Latency from acceptance to response: 14 clocks to one SPI slot pair (up to ~512 clocks).
- Throughput: at most one transaction per SPI slot (two per 8-slot frame).

## Test plan
- Read, default parameters: accept read at 0x1F000 in a CPU slot; model returns 0xA5 → bus_active_o rises T+1, ram_oe_n_o low T+3–T+10, rsp_valid_o at T+13 with rsp_data_o=0xA5.
- Write: write 0x3C to 0x08000 → bus_data_oe_o=1 T+1–T+12, ram_we_n_o low T+3–T+10, bus_data_o=0x3C, ram_oe_n_o stays 1, rsp_valid_o at T+13.
- Non-SPI strobes: request pending through CPU and video slot strobes → no bus activity; transaction starts on the first SPI strobe.
- Request accepted on an SPI strobe clock → no start on that strobe; starts at the next SPI slot's strobe (the other SPI slot of the frame).
- Grant drop: deassert spi_grant_i at T+5 → all bus outputs inactive at T+6, no rsp_valid_o; completes normally at the next SPI strobe.
- Reset: assert reset_n_i low during ACCESS → ram_we_n_o/ram_oe_n_o go high asynchronously, req_ready_o=1; the request is not executed after release.
